// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, result record and saturation limit helper for the accumulating ALU
package alu_pkg;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_ACC, OP_CLR} op_t;
   typedef struct packed {
      logic [31:0] value;
      logic        nA;
      logic        nB;
      logic        nR;
      logic        zero;
      logic        over;
   } result_t;
   // Signed max (neg=0) or min (neg=1) for a width, sign-extended to 32 bits
   function automatic logic [31:0] sat_limit(input int width, input logic neg);
      logic [31:0] m;
      m = 32'h7fff_ffff >> (32 - width);
      return neg ? ~m : m;
   endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational add/sub/accumulate/clear with overflow detection and optional saturation
module alu_core import alu_pkg::*; #(
   parameter int WIDTH    = 6,
   parameter bit SATURATE = 1'b0
) (
   input  op_t              op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] acc,
   output result_t          res
);
   logic [WIDTH-1:0] s, fin;
   logic [WIDTH:0]   sum;
   logic             sub, clr, ovf;
   always_comb begin
      sub = op == OP_SUB;
      clr = op == OP_CLR;
      s   = op == OP_ACC ? acc : B;
      sum = sub ? {A[WIDTH-1], A} - {s[WIDTH-1], s} : {A[WIDTH-1], A} + {s[WIDTH-1], s};
      // sign-extended operands overflow exactly when the two top bits disagree
      ovf = !clr && sum[WIDTH] != sum[WIDTH-1];
      fin = clr ? '0 : (ovf && SATURATE) ? WIDTH'(sat_limit(WIDTH, A[WIDTH-1])) : sum[WIDTH-1:0];
      res = '{value: 32'(fin), nA: !clr && A[WIDTH-1], nB: !clr && s[WIDTH-1],
              nR: fin[WIDTH-1], zero: fin == '0, over: ovf};
   end
endmodule

// File: rtl/alu_accum.sv
// alu_accum: registered ALU with accumulator, sticky overflow and a single-entry valid/ready output
module alu_accum import alu_pkg::*; #(
   parameter int WIDTH    = 6,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             nA_flag,
   output logic             nB_flag,
   output logic             nR_flag,
   output logic             zero_flag,
   output logic             over_flag,
   output logic             over_sticky
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q;
   result_t          res;
   logic             xfer;
   op_t              op_e;
   assign op_e = op_t'(op);
   alu_core #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_core (
      .op(op_e), .A(A), .B(B), .acc(acc_q), .res(res)
   );
   always_comb begin
      in_ready = state_q == EMPTY || out_ready;
      xfer     = in_valid && in_ready;
      state_d  = xfer ? FULL : out_ready ? EMPTY : state_q;
   end
   assign out_valid = state_q == FULL;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         acc_q       <= '0;
         result      <= '0;
         nA_flag     <= 1'b0;
         nB_flag     <= 1'b0;
         nR_flag     <= 1'b0;
         zero_flag   <= 1'b0;
         over_flag   <= 1'b0;
         over_sticky <= 1'b0;
      end else begin
         state_q <= state_d;
         if (xfer) begin
            result      <= res.value[WIDTH-1:0];
            nA_flag     <= res.nA;
            nB_flag     <= res.nB;
            nR_flag     <= res.nR;
            zero_flag   <= res.zero;
            over_flag   <= res.over;
            over_sticky <= op_e != OP_CLR && (over_sticky || res.over);
            if (op_e == OP_ACC || op_e == OP_CLR) acc_q <= res.value[WIDTH-1:0];
         end
      end
   end
endmodule

// File: tb/tb_alu_accum.sv
// tb_alu_accum: directed checks of the accumulating ALU in 6-bit wrap/saturate and 16-bit model-swept configurations
module tb_alu_accum;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   int n_chk = 0, n_fail = 0;
   logic       iv = 1'b0, ordy = 1'b1;
   logic [1:0] op6 = 2'd0;
   logic [5:0] a6 = '0, b6 = '0;
   logic       w_ir, w_v, w_na, w_nb, w_nr, w_z, w_o, w_s;
   logic       s_ir, s_v, s_na, s_nb, s_nr, s_z, s_o, s_s;
   logic [5:0] w_r, s_r;
   logic        iv16 = 1'b0;
   logic [1:0]  op16 = 2'd0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        x_ir, x_v, x_na, x_nb, x_nr, x_z, x_o, x_s;
   logic        y_ir, y_v, y_na, y_nb, y_nr, y_z, y_o, y_s;
   logic [15:0] x_r, y_r;
   logic signed [15:0] acc_w = '0, acc_s = '0;
   logic        st_w = 1'b0, st_s = 1'b0;
   logic [21:0] exp_w, exp_s;

   alu_accum #(.WIDTH(6), .SATURATE(1'b0)) dut_w (.clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(w_ir),
      .op(op6), .A(a6), .B(b6), .out_valid(w_v), .out_ready(ordy), .result(w_r), .nA_flag(w_na),
      .nB_flag(w_nb), .nR_flag(w_nr), .zero_flag(w_z), .over_flag(w_o), .over_sticky(w_s));
   alu_accum #(.WIDTH(6), .SATURATE(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(s_ir),
      .op(op6), .A(a6), .B(b6), .out_valid(s_v), .out_ready(ordy), .result(s_r), .nA_flag(s_na),
      .nB_flag(s_nb), .nR_flag(s_nr), .zero_flag(s_z), .over_flag(s_o), .over_sticky(s_s));
   alu_accum #(.WIDTH(16), .SATURATE(1'b0)) dut_x (.clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(x_ir),
      .op(op16), .A(a16), .B(b16), .out_valid(x_v), .out_ready(ordy), .result(x_r), .nA_flag(x_na),
      .nB_flag(x_nb), .nR_flag(x_nr), .zero_flag(x_z), .over_flag(x_o), .over_sticky(x_s));
   alu_accum #(.WIDTH(16), .SATURATE(1'b1)) dut_y (.clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(y_ir),
      .op(op16), .A(a16), .B(b16), .out_valid(y_v), .out_ready(ordy), .result(y_r), .nA_flag(y_na),
      .nB_flag(y_nb), .nR_flag(y_nr), .zero_flag(y_z), .over_flag(y_o), .over_sticky(y_s));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do6(input logic [1:0] o, input logic [5:0] a, input logic [5:0] b);
      @(negedge clk);
      iv = 1'b1; op6 = o; a6 = a; b6 = b;
      @(posedge clk);
      #1 iv = 1'b0;
   endtask

   // Independent reference: exact integer math, then wrap or clamp
   task automatic ref16(input logic [1:0] o, input logic signed [15:0] a, input logic signed [15:0] b,
                        input bit sat, inout logic signed [15:0] acc, inout logic st, output logic [21:0] e);
      int s;
      logic ov;
      logic [15:0] v;
      s  = o == 2'd1 ? int'(a) - int'(b) : o == 2'd2 ? int'(a) + int'(acc) : int'(a) + int'(b);
      ov = o != 2'd3 && (s > 32767 || s < -32768);
      v  = o == 2'd3 ? 16'd0 : (ov && sat) ? (s > 0 ? 16'h7fff : 16'h8000) : s[15:0];
      e  = {v, ov, o != 2'd3 && a[15], o != 2'd3 && (o == 2'd2 ? acc[15] : b[15]), v[15], v == 16'd0,
            o != 2'd3 && (st || ov)};
      st = o != 2'd3 && (st || ov);
      if (o >= 2'd2) acc = v;
   endtask

   task automatic do16(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      iv16 = 1'b1; op16 = o; a16 = a; b16 = b;
      ref16(o, a, b, 1'b0, acc_w, st_w, exp_w);
      ref16(o, a, b, 1'b1, acc_s, st_s, exp_s);
      @(posedge clk);
      #1;
      chk("w16", {x_r, x_o, x_na, x_nb, x_nr, x_z, x_s}, exp_w);
      chk("s16", {y_r, y_o, y_na, y_nb, y_nr, y_z, y_s}, exp_s);
      chk("v16", {x_v, y_v}, 2'b11);
   endtask

   initial begin
      #12;
      chk("rst_valid", {w_v, s_v, x_v}, 3'b000);
      chk("rst_result", {w_r, s_r}, 12'd0);
      chk("rst_flags", {w_na, w_nb, w_nr, w_z, w_o, w_s}, 6'd0);
      chk("rst_in_ready", {w_ir, s_ir}, 2'b11);
      @(negedge clk) rst_n = 1'b1;
      do6(2'd0, 6'd20, 6'd15);
      chk("add_ovf_w", {w_r, w_o, w_nr, w_s, w_v}, {6'b100011, 4'b1111});
      chk("add_ovf_s", {s_r, s_o, s_nr, s_s}, {6'd31, 3'b101});
      do6(2'd3, 6'd0, 6'd0);
      chk("clr_w", {w_r, w_z, w_s, w_o, w_na}, {6'd0, 4'b1000});
      chk("clr_s", {s_r, s_z, s_s}, {6'd0, 2'b10});
      do6(2'd1, 6'b100000, 6'd1);
      chk("sub_w", {w_r, w_o, w_na, w_nb}, {6'd31, 3'b110});
      chk("sub_s", {s_r, s_o, s_na}, {6'b100000, 2'b11});
      do6(2'd3, 6'd0, 6'd0);
      for (int i = 1; i <= 3; i++) begin
         do6(2'd2, 6'd10, 6'd0);
         chk("acc10", {w_r, s_r}, {6'(10 * i), 6'(10 * i)});
      end
      do6(2'd2, 6'd5, 6'd0);
      chk("acc_ovf", {w_r, s_r, w_o, s_o}, {6'b100011, 6'd31, 2'b11});
      do6(2'd2, 6'd0, 6'd0);
      chk("acc_read", {w_r, s_r, w_nb, s_nb, w_o, s_s}, {6'b100011, 6'd31, 4'b1001});
      do6(2'd0, 6'd1, 6'd1);
      chk("add_keep", {w_r, s_r}, {6'd2, 6'd2});
      do6(2'd2, 6'd0, 6'd0);
      chk("acc_kept", {w_r, s_r}, {6'b100011, 6'd31});
      @(negedge clk);
      iv = 1'b1; op6 = 2'd0;
      for (int i = 0; i < 3; i++) begin
         a6 = 6'(2 * i + 1); b6 = 6'(2 * i + 2);
         @(posedge clk);
         #1 chk("b2b", {w_r, w_v}, {6'(4 * i + 3), 1'b1});
         @(negedge clk);
      end
      a6 = 6'd7; b6 = 6'd8; ordy = 1'b0;
      #1 chk("stall_ready", {w_ir, s_ir}, 2'b00);
      repeat (3) begin
         @(posedge clk);
         #1 chk("stall_hold", {w_r, w_v, w_o}, {6'd11, 2'b10});
      end
      @(negedge clk) ordy = 1'b1;
      #1 chk("unstall_ready", w_ir, 1'b1);
      @(posedge clk);
      #1 chk("unstall_xfer", {w_r, w_v}, {6'd15, 1'b1});
      iv = 1'b0;
      @(posedge clk);
      #1 chk("drain", {w_v, s_v}, 2'b00);
      do6(2'd3, 6'd0, 6'd0);
      repeat (3) do6(2'd2, 6'd10, 6'd0);
      ordy = 1'b0;
      chk("pre_rst", {w_r, w_v}, {6'd30, 1'b1});
      #2 rst_n = 1'b0;
      #1 chk("async_rst", {w_v, w_r, w_nr, w_z, s_v, s_r}, 16'd0);
      @(negedge clk) begin rst_n = 1'b1; ordy = 1'b1; end
      do6(2'd2, 6'd1, 6'd0);
      chk("post_rst_acc", {w_r, s_r}, {6'd1, 6'd1});
      do16(2'd3, 16'd0, 16'd0);
      do16(2'd0, 16'd32767, 16'd1);
      do16(2'd1, 16'h8000, 16'd1);
      do16(2'd2, 16'd32767, 16'd0);
      do16(2'd2, 16'd1, 16'd0);
      do16(2'd2, 16'h8000, 16'd0);
      for (int i = 0; i < 40; i++)
         do16(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
      iv16 = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_accum.md
# alu_accum

Parametrised, registered successor to the team's 6-bit signed adder. It adds, subtracts or accumulates WIDTH-bit two's-complement operands and can clear its accumulator. Results are wrap-around or saturating, selected per instance. Each result carries sign, zero and overflow flags plus a sticky overflow flag, and leaves through a single-entry valid/ready output register. The block sits between the operand-entry front end and the LED/display driver, and is the arithmetic unit for the board ALU.

## Interface
- WIDTH, 6: operand and result width in bits, two's complement; legal range 2..32.
- SATURATE, 0: 0 = wrap on overflow; 1 = clamp to the signed max/min on overflow.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- in_valid  in  1  an operation is presented.
- in_ready  out  1  the block can accept an operation this cycle.
- op  in  2  operation code: 0 ADD, 1 SUB, 2 ACC, 3 CLR.
- A  in  WIDTH  operand A, signed.
- B  in  WIDTH  operand B, signed; ignored for ACC and CLR.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  the consumer takes the result this cycle.
- result  out  WIDTH  registered result.
- nA_flag, nB_flag  out  1 each  sign bits of the operands that produced this result.
- nR_flag  out  1  result is negative.
- zero_flag  out  1  result equals 0.
- over_flag  out  1  this operation overflowed.
- over_sticky  out  1  an overflow has occurred since the last CLR or reset.

## Operation
- Handshake:
  - in_ready = !out_valid || out_ready, which is combinational from out_ready only.
  - A transfer happens when in_valid && in_ready.
  - Output states: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY goes to FULL on a transfer.
  - FULL with out_ready and no new transfer goes to EMPTY.
  - FULL with out_ready and a new transfer stays FULL with the new result loaded.
  - While FULL and out_ready=0, the output register and all flags are held stable.
- Arithmetic: all math is done at WIDTH+1 bits, then reduced.
  - ADD: A+B.
  - SUB: A−B.
  - ACC: acc+A.
  - CLR: the result is 0.
- Overflow:
  - ADD and ACC overflow when both operand signs are equal and the raw WIDTH-bit sum sign differs from them.
  - SUB overflows when the signs of A and B differ and the raw sign differs from A.
  - For CLR, over_flag is 0.
- Result on overflow:
  - SATURATE=0: the result is the raw WIDTH-bit value (wrap-around).
  - SATURATE=1: the result is 2^(WIDTH−1)−1 if the first operand was non-negative, otherwise −2^(WIDTH−1).
  - over_flag is asserted in both modes.
- Flags:
  - nR_flag = result[WIDTH−1].
  - zero_flag = (result == 0), computed on the final (possibly saturated) value.
  - For ACC, nA_flag and nB_flag are the sign of A and the sign of the old acc.
  - For CLR, nA_flag and nB_flag are 0.
- Accumulator:
  - acc updates only on a transfer with op ACC (loads the final result) or op CLR (loads 0).
  - ADD and SUB leave acc untouched.
- Sticky overflow:
  - over_sticky sets on a transfer whose over_flag=1.
  - It clears on a CLR transfer.
  - It is visible in the same cycle as that result.

## Timing
- Latency is one cycle: the transfer happens at edge N, and out_valid, result and the flags are valid after edge N.
- Throughput is one operation per cycle while out_ready=1.
- Reset values: out_valid=0, result=0, every flag=0, over_sticky=0, acc=0. in_ready is therefore 1 during reset.
- Reset asserted mid-operation discards the held result and the accumulator immediately, asynchronously.
- The first transfer is accepted at the first rising edge after rst_n deasserts.
- When a consume and a new transfer coincide, no bubble is inserted and no result is lost or duplicated.
- No combinational path exists from A, B, op or in_valid to any output.

## Structure
- Package alu_pkg holds:
  - the op_t enum (OP_ADD, OP_SUB, OP_ACC, OP_CLR);
  - a result_t struct carrying value, nA, nB, nR, zero and over;
  - a helper function computing the signed max/min for a given width.
- Sub-module alu_core (combinational, parametrised by WIDTH and SATURATE):
  - inputs: op, A, B, acc;
  - output: result_t.
- alu_accum holds the acc register, the sticky flag, the output register and the handshake logic.

## Test plan
- WIDTH=6, SATURATE=0, ADD A=20 B=15 → result=−29 (6'b100011), over_flag=1, nR_flag=1, over_sticky=1; then CLR → result=0, zero_flag=1, over_sticky=0.
- WIDTH=6, SATURATE=1, SUB A=−32 B=1 → result=−32, over_flag=1, nA_flag=1; the same stimulus with SATURATE=0 → result=31.
- CLR, then ACC A=10 three times → results 10, 20, 30; then ACC A=5 → −29 with SATURATE=0 or 31 with SATURATE=1, acc equal to that value in both cases; then ADD 1,1 → 2 with acc unchanged.
- Back-to-back ADDs with out_ready=1 → one result per cycle in order; drop out_ready for 3 cycles → in_ready=0, result held stable, no transfer lost.
- Assert rst_n=0 asynchronously while FULL with acc=30 → out_valid, result, flags and acc all go to 0 without waiting for a clock edge; the next ACC A=1 → result 1.
- WIDTH=16 sweep with random ADD/SUB/ACC/CLR against a reference model, including 32767+1 and −32768−1 → wrap/saturate results and flags match the model exactly.
